// File: rtl/unpool_pe_dc.sv
// Max-unpooling stage for the decoder: buffers one pooled row, then emits the POOL_H x (POOL_W*W_IN) block.
// UNPOOL_NN_EN switches to nearest-neighbour upsampling (the stored index is ignored).

module unpool_pe_dc_slot #(
  parameter int D   = 512,
  parameter int PIW = 2
) (
  input  logic           i_clk,
  input  logic           i_we,
  input  logic [D-1:0]   i_data,
  input  logic [PIW-1:0] i_pindex,
  input  logic [PIW-1:0] i_k,
  output logic [D-1:0]   o_data
);
  logic [D-1:0]   r_data;
  logic [PIW-1:0] r_pindex;

  // Buffer contents are don't-care after reset, so no reset is needed here.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_data   <= i_data;
      r_pindex <= i_pindex;
    end
  end

`ifdef UNPOOL_NN_EN
  logic w_unused_idx;
  assign w_unused_idx = ^{r_pindex, i_k};
  assign o_data = r_data;
`else
  // An index outside the window never equals a legal k, so it yields zeros.
  assign o_data = (r_pindex == i_k) ? r_data : '0;
`endif
endmodule

module unpool_pe_dc #(
  parameter  int D            = 512,
  parameter  int POOL_H       = 2,
  parameter  int POOL_W       = 2,
  parameter  int W_IN         = 16,
  localparam int PINDEX_WIDTH = (POOL_H*POOL_W > 1) ? $clog2(POOL_H*POOL_W) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [D-1:0]            i_in_data,
  input  logic [PINDEX_WIDTH-1:0] i_in_pindex,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [D-1:0]            o_out_data,
  output logic                    o_out_eol,
  output logic                    o_out_eof
);
  localparam int CW = (W_IN   > 1) ? $clog2(W_IN)   : 1;
  localparam int HW = (POOL_H > 1) ? $clog2(POOL_H) : 1;
  localparam int WW = (POOL_W > 1) ? $clog2(POOL_W) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;

  state_t                    r_state;
  logic [CW-1:0]             r_col;
  logic [CW-1:0]             r_c;
  logic [HW-1:0]             r_ph;
  logic [WW-1:0]             r_pw;
  logic                      r_in_ready;
  logic                      r_out_valid;

  logic                      w_in_hs, w_out_hs;
  logic                      w_col_last, w_c_last, w_ph_last, w_pw_last;
  logic [PINDEX_WIDTH-1:0]   w_k;
  logic [W_IN-1:0][D-1:0]    w_slot;

  assign w_in_hs    = i_in_valid & r_in_ready;
  assign w_out_hs   = r_out_valid & i_out_ready;
  assign w_col_last = (r_col == CW'(W_IN-1));
  assign w_c_last   = (r_c   == CW'(W_IN-1));
  assign w_ph_last  = (r_ph  == HW'(POOL_H-1));
  assign w_pw_last  = (r_pw  == WW'(POOL_W-1));
  assign w_k        = PINDEX_WIDTH'(int'(r_ph) * POOL_W + int'(r_pw));

  genvar gi;
  generate
    for (gi = 0; gi < W_IN; gi++) begin : g_slot
      unpool_pe_dc_slot #(.D(D), .PIW(PINDEX_WIDTH)) u_slot (
        .i_clk    (i_clk),
        .i_we     (w_in_hs & (r_col == CW'(gi))),
        .i_data   (i_in_data),
        .i_pindex (i_in_pindex),
        .i_k      (w_k),
        .o_data   (w_slot[gi])
      );
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_col       <= '0;
      r_c         <= '0;
      r_ph        <= '0;
      r_pw        <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state    <= LOAD;
          r_in_ready <= 1'b1;
        end
        LOAD: begin
          if (w_in_hs) begin
            if (w_col_last) begin
              r_col       <= '0;
              r_c         <= '0;
              r_ph        <= '0;
              r_pw        <= '0;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= EMIT;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        EMIT: begin
          // Raster walk: pw fastest, then input column, then window row.
          if (w_out_hs) begin
            if (!w_pw_last) begin
              r_pw <= r_pw + 1'b1;
            end else begin
              r_pw <= '0;
              if (!w_c_last) begin
                r_c <= r_c + 1'b1;
              end else begin
                r_c <= '0;
                if (!w_ph_last) begin
                  r_ph <= r_ph + 1'b1;
                end else begin
                  r_ph        <= '0;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= LOAD;
                end
              end
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Outputs come only from registered counters and the buffer, so they hold during a stall.
  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_valid ? w_slot[r_c] : '0;
  assign o_out_eol   = r_out_valid & w_c_last & w_pw_last;
  assign o_out_eof   = r_out_valid & w_c_last & w_pw_last & w_ph_last;
endmodule

// File: tb/tb_unpool_pe_dc.sv
// Directed bench for unpool_pe_dc: a 2x2/W_IN=4 instance and a 1x3/W_IN=2 instance checked against a row-level model.
// Build with +define+UNPOOL_NN_EN to check the nearest-neighbour variant.
module tb_unpool_pe_dc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_vld, a_irdy, a_ordy, a_oval, a_eol, a_eof;
  logic [7:0] a_dat, a_odat;
  logic [1:0] a_pix;
  logic       b_vld, b_irdy, b_ordy, b_oval, b_eol, b_eof;
  logic [7:0] b_dat, b_odat;
  logic [1:0] b_pix;

  unpool_pe_dc #(.D(8), .POOL_H(2), .POOL_W(2), .W_IN(4)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(a_vld), .o_in_ready(a_irdy),
    .i_in_data(a_dat), .i_in_pindex(a_pix), .o_out_valid(a_oval), .i_out_ready(a_ordy),
    .o_out_data(a_odat), .o_out_eol(a_eol), .o_out_eof(a_eof));

  unpool_pe_dc #(.D(8), .POOL_H(1), .POOL_W(3), .W_IN(2)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(b_vld), .o_in_ready(b_irdy),
    .i_in_data(b_dat), .i_in_pindex(b_pix), .o_out_valid(b_oval), .i_out_ready(b_ordy),
    .o_out_data(b_odat), .o_out_eol(b_eol), .o_out_eof(b_eof));

  typedef struct packed { logic [7:0] d; logic eol; logic eof; } beat_t;
  typedef beat_t bq_t[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  beat_t aexp[$], bexp[$], acap[$], bcap[$];
  logic [7:0] ard[$], brd[$];
  int arp[$], brp[$];
  beat_t a_prev, b_prev;
  logic a_stall = 0, b_stall = 0, a_lat = 0, b_lat = 0, a_gap = 0, a_mode = 0;
  int a_eof_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Row-level model: expands one captured input row into the full output block.
  function automatic bq_t expand(input int H, input int PW, input int W,
                                 input logic [7:0] d[$], input int p[$]);
    bq_t q;
    beat_t b;
    for (int ph = 0; ph < H; ph++)
      for (int c = 0; c < W; c++)
        for (int pw = 0; pw < PW; pw++) begin
`ifdef UNPOOL_NN_EN
          b.d = d[c];
`else
          b.d = (p[c] == ph*PW + pw) ? d[c] : 8'h00;
`endif
          b.eol = (c == W-1) && (pw == PW-1);
          b.eof = b.eol && (ph == H-1);
          q.push_back(b);
        end
    return q;
  endfunction

  task automatic cmp_a();
    bq_t t;
    if (!rst_n) begin
      aexp.delete(); ard.delete(); arp.delete();
      a_stall = 0; a_lat = 0;
    end else begin
      if (a_lat) begin chk("a_first_valid_latency", a_oval, 1); a_lat = 0; end
      if (a_oval) chk("a_in_ready_during_emit", a_irdy, 0);
      if (a_vld && a_irdy) begin
        if (a_gap) begin chk("a_next_row_gap", cyc - a_eof_cyc, 1); a_gap = 0; end
        ard.push_back(a_dat); arp.push_back(int'(a_pix));
        if (ard.size() == 4) begin
          t = expand(2, 2, 4, ard, arp);
          foreach (t[i]) aexp.push_back(t[i]);
          ard.delete(); arp.delete();
          a_lat = 1;
        end
      end
      if (a_stall) begin
        chk("a_stall_valid", a_oval, 1);
        chk("a_stall_data", a_odat, a_prev.d);
        chk("a_stall_eol", a_eol, a_prev.eol);
        chk("a_stall_eof", a_eof, a_prev.eof);
      end
      if (a_oval) begin
        if (aexp.size() == 0) chk("a_unexpected_beat", aexp.size(), 1);
        else begin
          chk("a_data", a_odat, aexp[0].d);
          chk("a_eol", a_eol, aexp[0].eol);
          chk("a_eof", a_eof, aexp[0].eof);
          if (a_ordy) begin
            acap.push_back({a_odat, a_eol, a_eof});
            if (a_eof) a_eof_cyc = cyc;
            void'(aexp.pop_front());
          end
        end
      end
      a_stall = a_oval && !a_ordy;
      a_prev = {a_odat, a_eol, a_eof};
    end
  endtask

  task automatic cmp_b();
    bq_t t;
    if (!rst_n) begin
      bexp.delete(); brd.delete(); brp.delete();
      b_stall = 0; b_lat = 0;
    end else begin
      if (b_lat) begin chk("b_first_valid_latency", b_oval, 1); b_lat = 0; end
      if (b_oval) chk("b_in_ready_during_emit", b_irdy, 0);
      if (b_vld && b_irdy) begin
        brd.push_back(b_dat); brp.push_back(int'(b_pix));
        if (brd.size() == 2) begin
          t = expand(1, 3, 2, brd, brp);
          foreach (t[i]) bexp.push_back(t[i]);
          brd.delete(); brp.delete();
          b_lat = 1;
        end
      end
      if (b_oval) begin
        if (bexp.size() == 0) chk("b_unexpected_beat", bexp.size(), 1);
        else begin
          chk("b_data", b_odat, bexp[0].d);
          chk("b_eol", b_eol, bexp[0].eol);
          chk("b_eof", b_eof, bexp[0].eof);
          if (b_ordy) begin
            bcap.push_back({b_odat, b_eol, b_eof});
            void'(bexp.pop_front());
          end
        end
      end
    end
  endtask

  task automatic push_a(input logic [7:0] d, input logic [1:0] p);
    int g = 0;
    logic ok = 0;
    a_vld = 1; a_dat = d; a_pix = p;
    while (!ok && g < 200) begin
      @(negedge clk); ok = a_irdy;
      @(posedge clk); #1; g++;
    end
    if (!ok) chk("a_push_timeout", ok, 1);
    a_vld = 0;
  endtask

  task automatic push_b(input logic [7:0] d, input logic [1:0] p);
    int g = 0;
    logic ok = 0;
    b_vld = 1; b_dat = d; b_pix = p;
    while (!ok && g < 200) begin
      @(negedge clk); ok = b_irdy;
      @(posedge clk); #1; g++;
    end
    if (!ok) chk("b_push_timeout", ok, 1);
    b_vld = 0;
  endtask

  task automatic idle_a(input int n);
    a_vld = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_eof(input logic is_b);
    int g = 0;
    logic done = 0;
    while (!done && g < 400) begin
      @(negedge clk);
      done = is_b ? (b_oval && b_ordy && b_eof) : (a_oval && a_ordy && a_eof);
      g++;
    end
    chk(is_b ? "b_eof_timeout" : "a_eof_timeout", done, 1);
    @(posedge clk); #1;
  endtask

  task automatic chk_row_a(input string nm, input logic [7:0] lit[16]);
    chk({nm, "_count"}, acap.size(), 16);
    for (int i = 0; i < 16 && i < acap.size(); i++) begin
      chk({nm, "_data"}, acap[i].d, lit[i]);
      chk({nm, "_eol"}, acap[i].eol, (i == 7 || i == 15));
      chk({nm, "_eof"}, acap[i].eof, (i == 15));
    end
  endtask

`ifdef UNPOOL_NN_EN
  logic [7:0] lit1[16] = '{8'hA1,8'hA1,8'hB2,8'hB2,8'hC3,8'hC3,8'hD4,8'hD4,
                           8'hA1,8'hA1,8'hB2,8'hB2,8'hC3,8'hC3,8'hD4,8'hD4};
  logic [7:0] lit4[16] = '{8'h11,8'h11,8'h22,8'h22,8'h33,8'h33,8'h44,8'h44,
                           8'h11,8'h11,8'h22,8'h22,8'h33,8'h33,8'h44,8'h44};
  logic [7:0] litb[6]  = '{8'h5A,8'h5A,8'h5A,8'hC7,8'hC7,8'hC7};
`else
  logic [7:0] lit1[16] = '{8'hA1,8'h00,8'h00,8'hB2,8'h00,8'h00,8'h00,8'h00,
                           8'h00,8'h00,8'h00,8'h00,8'hC3,8'h00,8'h00,8'hD4};
  logic [7:0] lit4[16] = '{8'h00,8'h00,8'h00,8'h00,8'h00,8'h33,8'h44,8'h00,
                           8'h00,8'h11,8'h22,8'h00,8'h00,8'h00,8'h00,8'h00};
  logic [7:0] litb[6]  = '{8'h00,8'h00,8'h00,8'h00,8'hC7,8'h00};
`endif

  initial begin
    int n, t;
    a_vld = 0; a_dat = 0; a_pix = 0; a_ordy = 1;
    b_vld = 0; b_dat = 0; b_pix = 0; b_ordy = 1;
    fork
      forever begin @(negedge clk); cyc++; cmp_a(); cmp_b(); end
      forever begin @(posedge clk); #1; a_ordy = a_mode ? ~a_ordy : 1'b1; end
      begin #400000; $display("FAIL watchdog expired"); $fatal(1); end
    join_none

    // Reset state
    #2;
    chk("rst_a_in_ready", a_irdy, 0); chk("rst_a_out_valid", a_oval, 0);
    chk("rst_a_out_data", a_odat, 0); chk("rst_a_eol", a_eol, 0); chk("rst_a_eof", a_eof, 0);
    chk("rst_b_in_ready", b_irdy, 0); chk("rst_b_out_valid", b_oval, 0);
    @(posedge clk); #1; rst_n = 1;
    chk("a_in_ready_before_first_edge", a_irdy, 0);
    @(posedge clk); #1;
    chk("a_in_ready_after_first_edge", a_irdy, 1);

    // Basic index unpool
    acap.delete();
    push_a(8'hA1, 0); push_a(8'hB2, 1); push_a(8'hC3, 2); push_a(8'hD4, 3);
    wait_eof(0);
    chk_row_a("t1", lit1);

    // Backpressure: ready toggles every cycle
    acap.delete(); a_mode = 1;
    push_a(8'hA1, 0); push_a(8'hB2, 1); push_a(8'hC3, 2); push_a(8'hD4, 3);
    wait_eof(0);
    a_mode = 0;
    chk_row_a("t2", lit1);

    // Bubbles 1,0,0,1,1,0,1 then valid held high through the whole emit phase
    push_a(8'h5A, 1); idle_a(2); push_a(8'h6B, 3); push_a(8'h7C, 0); idle_a(1); push_a(8'h8D, 2);
    a_gap = 1;
    push_a(8'h90, 0);
    chk("a_gap_observed", a_gap, 0);
    push_a(8'h91, 1); push_a(8'h92, 2); push_a(8'h93, 3);
    wait_eof(0);

    // Reset during emit, with beat 5 on the output
    push_a(8'hE1, 0); push_a(8'hE2, 1); push_a(8'hE3, 2); push_a(8'hE4, 3);
    n = 0; t = 0;
    while (n < 4 && t < 200) begin @(negedge clk); if (a_oval && a_ordy) n++; t++; end
    chk("a_beats_before_reset", n, 4);
    @(posedge clk); #2; rst_n = 0; #1;
    chk("midrst_out_valid", a_oval, 0); chk("midrst_in_ready", a_irdy, 0);
    chk("midrst_out_data", a_odat, 0); chk("midrst_eol", a_eol, 0); chk("midrst_eof", a_eof, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1; rst_n = 1;
    chk("postrst_in_ready_low", a_irdy, 0);
    @(posedge clk); #1;
    chk("postrst_in_ready_high", a_irdy, 1);
    acap.delete();
    push_a(8'h11, 3); push_a(8'h22, 2); push_a(8'h33, 1); push_a(8'h44, 0);
    wait_eof(0);
    chk_row_a("t4", lit4);

    // 1x3 window with an out-of-range index
    bcap.delete();
    push_b(8'h5A, 3); push_b(8'hC7, 1);
    wait_eof(1);
    chk("tb_count", bcap.size(), 6);
    for (int i = 0; i < 6 && i < bcap.size(); i++) begin
      chk("tb_data", bcap[i].d, litb[i]);
      chk("tb_eol", bcap[i].eol, (i == 5));
      chk("tb_eof", bcap[i].eof, (i == 5));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("a_model_drained", aexp.size(), 0);
    chk("b_model_drained", bexp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
